param_universal_shift_register: RTL and testbench
=================================================

Name: param_universal_shift_register

Overview:
- WIDTH-parametrised universal shift register that extends the 4-bit hold/shift/load register.
- Adds rotate, arithmetic shift, clear, separate left/right serial inputs, registered serial outputs, and a clock enable.
- Adds a burst engine: one start command performs COUNT consecutive shift/rotate steps, with busy/done status.
- Used as a general datapath shifter/serializer in sequential blocks.

Parameters:
- WIDTH, 8, register width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH)+1, width of the burst count input; allows counts from 0 to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; a low level freezes all state, including a burst in progress.
- op  in  3  operation code (see Behaviour).
- start  in  1  starts a burst of the op on count; sampled only when idle.
- count  in  CNT_W  number of burst steps.
- sin_r  in  1  serial input that enters the MSB on a right shift.
- sin_l  in  1  serial input that enters the LSB on a left shift.
- pin  in  WIDTH  parallel load data.
- pout  out  WIDTH  register contents.
- sout_r  out  1  bit most recently shifted or rotated out of the LSB.
- sout_l  out  1  bit most recently shifted or rotated out of the MSB.
- busy  out  1  high while a burst is active.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: pout=0, sout_r=0, sout_l=0, busy=0, done=0, internal remaining count=0, latched op=000. Reset wins over every other input, including a burst in progress.
- Op codes, applied to the register R (one step per step cycle):
  - 000 HOLD: R unchanged.
  - 001 SHR: R = {sin_r, R[W-1:1]}; sout_r = old R[0].
  - 010 SHL: R = {R[W-2:0], sin_l}; sout_l = old R[W-1].
  - 011 LOAD: R = pin.
  - 100 ROR: R = {R[0], R[W-1:1]}; sout_r = old R[0].
  - 101 ROL: R = {R[W-2:0], R[W-1]}; sout_l = old R[W-1].
  - 110 ASR: R = {R[W-1], R[W-1:1]}; sout_r = old R[0].
  - 111 CLR: R = 0.
- Shift-class ops are 001, 010, 100, 101 and 110. A sout_* output updates only on a step that shifts out of its end; otherwise it holds.
- The FSM has two states, IDLE and BURST.
- IDLE, en=1, start=0: apply op once per cycle (direct mode); done=0.
- IDLE, en=1, start=1, op in the shift class, count!=0:
  - Perform the first step this cycle.
  - If count==1: stay IDLE and pulse done next cycle.
  - Otherwise: latch op, set remaining=count-1, go to BURST with busy=1.
- IDLE, en=1, start=1, count==0: R unchanged; done pulses next cycle.
- IDLE, en=1, start=1, op not in the shift class: apply op once and pulse done next cycle.
- BURST, en=1: apply the latched op; remaining decrements. When remaining reaches 0, return to IDLE, drop busy and raise done for one cycle, all in the same clock edge.
- BURST, en=0: no step, no decrement; busy stays high.
- While busy, op, start, pin and count are ignored. sin_r and sin_l are still sampled on every step.
- en=0 in IDLE: nothing changes and done is not pulsed. A done already asserted clears on the next edge regardless of en.
- Latency:
  - Direct mode: pout reflects the op one cycle after the edge at which it is sampled.
  - A burst of N steps with en held high: busy is high for N-1 cycles; done rises on the edge after the Nth step.
- Counts greater than WIDTH are legal and keep shifting (rotates wrap).

Decomposition:
- Package usr_pkg holds the op-code localparams (OP_HOLD … OP_CLR), the FSM state enum (ST_IDLE, ST_BURST) and an is_shift_op function.
- One combinational sub-module, usr_step, computes next R and the two shift-out bits from (R, op, sin_r, sin_l, pin). The top level instantiates it and holds the FSM, count and output registers.

Test Plan:
- Reset and load: rst=1 for 2 cycles → pout=0, busy=0, done=0. Then LOAD pin=8'hA5 → pout=8'hA5 next cycle.
- Direct shift: pout=8'hA5, SHR with sin_r=1 → 8'hD2 and sout_r=1. Then SHL with sin_l=0 → 8'hA4 and sout_l=1.
- Rotate and arithmetic shift: pout=8'h81, ROL → 8'h03. From 8'h81, ASR → 8'hC0 and sout_r=1.
- Burst with stall: pout=8'h01, start with ROL and count=3, en dropped for 2 cycles mid-burst → busy high 4 cycles, one done pulse, pout=8'h08. op changes during the burst have no effect.
- Edge counts: count=0 → done pulse only, pout unchanged. count=1 → single step, busy never asserted. count=9 with ROR (WIDTH=8) → net rotation of 1.
- Reset mid-burst: rst asserted during burst step 2 of 5 → next cycle pout=0, busy=0, no done pulse. A fresh burst then runs normally.
- Parameter sweep: repeat the shift/rotate scenarios at WIDTH=2 and WIDTH=16.

Source files
------------

// File: rtl/param_universal_shift_register_pkg.sv
// usr_pkg: op codes, burst FSM states and op classification for the universal shift register
package usr_pkg;
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;
    typedef enum logic {ST_IDLE, ST_BURST} state_t;
    function automatic logic is_shift_op(input logic [2:0] op);
        return op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR};
    endfunction
endpackage

// File: rtl/param_universal_shift_register_if.sv
// usr_if: command and status signals of the universal shift register
interface usr_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             en;
    logic [2:0]       op;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;
    modport master (
        output en, op, start, count, sin_r, sin_l, pin,
        input  pout, sout_r, sout_l, busy, done
    );
    modport slave (
        input  en, op, start, count, sin_r, sin_l, pin,
        output pout, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/param_universal_shift_register_step.sv
// usr_step: one combinational step of the register for a given op
module usr_step import usr_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic [2:0]       i_op,
    input  logic             i_sin_r,
    input  logic             i_sin_l,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_out_r,
    output logic             o_out_l,
    output logic             o_upd_r,
    output logic             o_upd_l
);
    assign o_out_r = i_r[0];
    assign o_out_l = i_r[WIDTH-1];
    assign o_upd_r = i_op inside {OP_SHR, OP_ROR, OP_ASR};
    assign o_upd_l = i_op inside {OP_SHL, OP_ROL};
    always_comb begin
        o_nxt = i_r;
        case (i_op)
            OP_SHR:  o_nxt = {i_sin_r, i_r[WIDTH-1:1]};
            OP_SHL:  o_nxt = {i_r[WIDTH-2:0], i_sin_l};
            OP_LOAD: o_nxt = i_pin;
            OP_ROR:  o_nxt = {i_r[0], i_r[WIDTH-1:1]};
            OP_ROL:  o_nxt = {i_r[WIDTH-2:0], i_r[WIDTH-1]};
            OP_ASR:  o_nxt = {i_r[WIDTH-1], i_r[WIDTH-1:1]};
            OP_CLR:  o_nxt = '0;
            default: o_nxt = i_r;
        endcase
    end
endmodule

// File: rtl/param_universal_shift_register.sv
// param_universal_shift_register: universal shift register with a counted burst engine
module param_universal_shift_register import usr_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic  clk,
    input logic  rst,
    usr_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic [2:0]       r_op, w_op_nxt, w_op;
    logic             r_sout_r, r_sout_l, r_done;
    logic             w_done_nxt, w_step;
    logic             w_out_r, w_out_l, w_upd_r, w_upd_l;
    // A running burst uses its latched op; the live op is ignored until it ends
    assign w_op = (r_state == ST_BURST) ? r_op : bus.op;
    usr_step #(.WIDTH(WIDTH)) u_step (
        .i_r(r_q), .i_op(w_op), .i_sin_r(bus.sin_r), .i_sin_l(bus.sin_l), .i_pin(bus.pin),
        .o_nxt(w_q_nxt), .o_out_r(w_out_r), .o_out_l(w_out_l), .o_upd_r(w_upd_r), .o_upd_l(w_upd_l)
    );
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        w_done_nxt  = 1'b0;
        w_step      = 1'b0;
        if (bus.en) begin
            if (r_state == ST_BURST) begin
                w_step    = 1'b1;
                w_rem_nxt = r_rem - CNT_W'(1);
                if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end else if (!bus.start) begin
                w_step = 1'b1;
            end else if (bus.count == '0) begin
                w_done_nxt = 1'b1;
            end else begin
                w_step = 1'b1;
                if (!is_shift_op(bus.op) || bus.count == CNT_W'(1)) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_BURST;
                    w_op_nxt    = bus.op;
                    w_rem_nxt   = bus.count - CNT_W'(1);
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_q      <= '0;
            r_rem    <= '0;
            r_op     <= OP_HOLD;
            r_sout_r <= 1'b0;
            r_sout_l <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
            r_done  <= w_done_nxt;
            if (w_step) r_q <= w_q_nxt;
            if (w_step && w_upd_r) r_sout_r <= w_out_r;
            if (w_step && w_upd_l) r_sout_l <= w_out_l;
        end
    end
    assign bus.pout   = r_q;
    assign bus.sout_r = r_sout_r;
    assign bus.sout_l = r_sout_l;
    assign bus.busy   = (r_state == ST_BURST);
    assign bus.done   = r_done;
endmodule

// File: tb/tb_param_universal_shift_register.sv
// tb_param_universal_shift_register: drives WIDTH=2/8/16 instances in lockstep against an arithmetic model
module tb_param_universal_shift_register;
    import usr_pkg::*;
    logic        clk = 1'b0;
    logic        rst, en, start, sr, sl;
    logic [2:0]  op;
    logic [4:0]  c;
    logic [15:0] pin;
    int checks = 0, fails = 0;
    always #5 clk = ~clk;
    usr_if #(.WIDTH(2))  b2 ();
    usr_if #(.WIDTH(8))  b8 ();
    usr_if #(.WIDTH(16)) b16 ();
    assign {b2.en, b2.op, b2.start, b2.sin_r, b2.sin_l} = {en, op, start, sr, sl};
    assign {b8.en, b8.op, b8.start, b8.sin_r, b8.sin_l} = {en, op, start, sr, sl};
    assign {b16.en, b16.op, b16.start, b16.sin_r, b16.sin_l} = {en, op, start, sr, sl};
    assign b2.count = c[1:0];
    assign b8.count = c[3:0];
    assign b16.count = c;
    assign b2.pin = pin[1:0];
    assign b8.pin = pin[7:0];
    assign b16.pin = pin;
    param_universal_shift_register #(.WIDTH(2))  d2  (.clk(clk), .rst(rst), .bus(b2));
    param_universal_shift_register #(.WIDTH(8))  d8  (.clk(clk), .rst(rst), .bus(b8));
    param_universal_shift_register #(.WIDTH(16)) d16 (.clk(clk), .rst(rst), .bus(b16));
    localparam int W[3]  = '{2, 8, 16};
    localparam int CW[3] = '{2, 4, 5};
    int   m_r[3], m_rem[3], m_op[3];
    logic m_sr[3], m_sl[3], m_busy[3], m_done[3];
    function automatic void apply(int k, int o);
        int w = W[k], top = 1 << (W[k] - 1), r = m_r[k];
        int lsb = r % 2, msb = r / top;
        case (o)
            1: m_r[k] = (r >> 1) + int'(sr) * top;
            2: m_r[k] = (r * 2 + int'(sl)) % (1 << w);
            3: m_r[k] = int'(pin) % (1 << w);
            4: m_r[k] = (r >> 1) + lsb * top;
            5: m_r[k] = (r * 2) % (1 << w) + msb;
            6: m_r[k] = (r >> 1) + msb * top;
            7: m_r[k] = 0;
            default: m_r[k] = r;
        endcase
        if (o == 1 || o == 4 || o == 6) m_sr[k] = lsb[0];
        if (o == 2 || o == 5) m_sl[k] = msb[0];
    endfunction
    function automatic void model(int k);
        int n = int'(c) % (1 << CW[k]);
        logic d = 1'b0;
        if (rst) begin
            m_r[k] = 0; m_rem[k] = 0; m_op[k] = 0;
            m_sr[k] = 0; m_sl[k] = 0; m_busy[k] = 0; m_done[k] = 0;
            return;
        end
        if (en) begin
            if (m_busy[k]) begin
                apply(k, m_op[k]);
                m_rem[k]--;
                if (m_rem[k] == 0) begin m_busy[k] = 0; d = 1; end
            end else if (!start) apply(k, int'(op));
            else if (n == 0) d = 1;
            else begin
                apply(k, int'(op));
                if (op == 0 || op == 3 || op == 7 || n == 1) d = 1;
                else begin m_busy[k] = 1; m_op[k] = int'(op); m_rem[k] = n - 1; end
            end
        end
        m_done[k] = d;
    endfunction
    function automatic logic [19:0] obs(int k);
        if (k == 0) return {14'b0, b2.pout, b2.sout_r, b2.sout_l, b2.busy, b2.done};
        if (k == 1) return {8'b0, b8.pout, b8.sout_r, b8.sout_l, b8.busy, b8.done};
        return {b16.pout, b16.sout_r, b16.sout_l, b16.busy, b16.done};
    endfunction
    task automatic chk(string tag, logic [19:0] o, logic [19:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model(k);
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("model_w%0d", W[k]), obs(k), {16'(m_r[k]), m_sr[k], m_sl[k], m_busy[k], m_done[k]});
    endtask
    task automatic set(logic [2:0] o, logic s, logic [4:0] n, logic [15:0] p);
        op = o; start = s; c = n; pin = p;
    endtask
    initial begin
        for (int k = 0; k < 3; k++) begin
            m_r[k] = 0; m_rem[k] = 0; m_op[k] = 0;
            m_sr[k] = 0; m_sl[k] = 0; m_busy[k] = 0; m_done[k] = 0;
        end
        rst = 1; en = 1; sr = 0; sl = 0;
        set(OP_HOLD, 0, 0, 0);
        step(); step();
        chk("reset", {8'b0, b8.pout, b8.busy, b8.done}, 20'h0);
        rst = 0;
        set(OP_LOAD, 0, 0, 16'h00A5); step();
        chk("load", 20'(b8.pout), 20'hA5);
        sr = 1; set(OP_SHR, 0, 0, 0); step();
        chk("shr", {11'b0, b8.pout, b8.sout_r}, {11'b0, 8'hD2, 1'b1});
        sl = 0; set(OP_SHL, 0, 0, 0); step();
        chk("shl", {11'b0, b8.pout, b8.sout_l}, {11'b0, 8'hA4, 1'b1});
        set(OP_LOAD, 0, 0, 16'h8181); step();
        set(OP_ROL, 0, 0, 0); step();
        chk("rol", 20'(b8.pout), 20'h03);
        set(OP_LOAD, 0, 0, 16'h8181); step();
        set(OP_ASR, 0, 0, 0); step();
        chk("asr", {11'b0, b8.pout, b8.sout_r}, {11'b0, 8'hC0, 1'b1});
        set(OP_LOAD, 0, 0, 16'h0001); step();
        set(OP_ROL, 1, 3, 0); step();
        chk("burst_first", {11'b0, b8.pout, b8.busy}, {11'b0, 8'h02, 1'b1});
        set(OP_SHR, 1, 7, 16'hFFFF); en = 0; step(); step();
        chk("burst_stall", {10'b0, b8.pout, b8.busy, b8.done}, {10'b0, 8'h02, 2'b10});
        en = 1; step();
        set(OP_CLR, 0, 0, 0); step();
        chk("burst_end", {10'b0, b8.pout, b8.busy, b8.done}, {10'b0, 8'h08, 2'b01});
        set(OP_HOLD, 0, 0, 0); step();
        chk("done_clear", 20'(b8.done), 20'h0);
        set(OP_ROL, 1, 0, 0); step();
        chk("count0", {10'b0, b8.pout, b8.busy, b8.done}, {10'b0, 8'h08, 2'b01});
        set(OP_ROL, 1, 1, 0); step();
        chk("count1", {10'b0, b8.pout, b8.busy, b8.done}, {10'b0, 8'h10, 2'b01});
        set(OP_LOAD, 0, 0, 16'h0096); step();
        set(OP_ROR, 1, 9, 0); step();
        set(OP_HOLD, 0, 0, 0);
        for (int i = 0; i < 20 && b8.busy; i++) step();
        chk("count9_ror", {10'b0, b8.pout, b8.busy, b8.done}, {10'b0, 8'h4B, 2'b01});
        set(OP_LOAD, 0, 0, 16'h0055); step();
        set(OP_SHL, 1, 5, 0); step();
        set(OP_HOLD, 0, 0, 0); rst = 1; step();
        chk("rst_mid", {10'b0, b8.pout, b8.busy, b8.done}, 20'h0);
        rst = 0; step();
        chk("rst_nodone", 20'(b8.done), 20'h0);
        set(OP_LOAD, 0, 0, 16'h0003); step();
        set(OP_ROL, 1, 2, 0); step();
        set(OP_HOLD, 0, 0, 0); step();
        chk("fresh_burst", {10'b0, b8.pout, b8.busy, b8.done}, {10'b0, 8'h0C, 2'b01});
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 60) == 0);
            en = ($urandom_range(0, 3) != 0);
            sr = 1'($urandom); sl = 1'($urandom);
            set(3'($urandom), $urandom_range(0, 3) == 0, 5'($urandom_range(0, 20)), 16'($urandom));
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
